sm4_key_exp_ctrl: RTL and testbench
===================================

Name: sm4_key_exp_ctrl

Overview:
Sequencer for the SM4 key schedule. It accepts a 128-bit master key, applies the FK whitening, and drives the existing combinational one_round_for_key_exp datapath for 32 iterations, one round per clock. It stores the 32 round keys in a local register file and exposes them through an asynchronous read port. The port supports forward (encrypt) and reversed (decrypt) order for the SM4 cipher core.

Parameters:
NUM_ROUNDS, 32, number of key-expansion rounds; fixed by SM4, other values unsupported
RK_W, 32, round-key width in bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start_i  input  1  request a key expansion; sampled only in IDLE
key_i  input  128  master key MK0..MK3, MK0 in bits [127:96]; sampled on the accepted start edge
busy_o  output  1  high while an expansion is in progress
done_o  output  1  one-cycle pulse when all 32 round keys are written
keys_valid_o  output  1  high while the register file holds a complete schedule for the last accepted key
rk_dec_i  input  1  0: rk_addr_i selects rk[addr]; 1: selects rk[31-addr]
rk_addr_i  input  5  round-key read index
rk_data_o  output  32  round key at the effective index; combinational read

Behaviour:
- Reset (async, rst=1), in any state including mid-expansion:
  - FSM=IDLE, round counter=0, state register=0, all rk entries=0.
  - busy_o=0, done_o=0, keys_valid_o=0, rk_data_o=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - On the edge where start_i=1, load state register with key_i XOR {A3B1BAC6, 56AA3350, 677D9197, B27022DC}.
  - On the same edge: counter=0, keys_valid_o cleared, next state ROUND.
  - start_i=0: remain in IDLE.
- ROUND:
  - Datapath inputs: data_in = state register, count_round_in = {1'b0, counter}, ck_parameter_in = CK(counter).
  - Each edge: state register <= result_out, rk[counter] <= rk_o, counter++.
  - At the edge where counter==31: write rk[31], go to DONE, set keys_valid_o.
  - Duration is exactly 32 cycles.
- DONE:
  - done_o=1 for exactly one cycle; next edge returns to IDLE.
  - keys_valid_o stays 1 until the next accepted start or reset.
- CK generation is combinational from counter i. Byte j (j=0 in MSB) = (28*i + 7*j) mod 256, 8-bit wrap.
  - CK(0) = 00070E15.
  - CK(1) = 1C232A31.
  - CK(31) = 646B7279.
- busy_o = (state==ROUND); it is also low in DONE.
- Latency: start accepted at edge E0; rk[k] written at edge E(k+1); done_o high in the cycle after E32; back in IDLE after E33.
- start_i while in ROUND or DONE: ignored and not queued.
- start_i asserted in the DONE cycle: ignored. start_i held high continuously re-triggers on the first IDLE cycle.
- Read port:
  - Effective index = rk_dec_i ? (31 - rk_addr_i) : rk_addr_i, 5-bit.
  - Reads during ROUND return current contents, which may be partial or stale. Consumers must gate on keys_valid_o.
- No arithmetic overflow concerns beyond the 5-bit counter. The counter never wraps inside ROUND because the exit is at 31.

Decomposition:
- Shared package sm4_pkg:
  - FK constants FK0..FK3.
  - SM4_ROUNDS=32.
  - FSM state encoding localparams.
  - CK byte step (7) and round step (28).
- Sub-modules:
  - Instantiate the existing one_round_for_key_exp unchanged.
  - One natural new sub-module, sm4_ck_gen: combinational, 5-bit index in, 32-bit CK out. It is reused by the cipher-side controller's tests.
  - The round-key register file stays inline.

Test Plan:
- Reset then start with key 0123456789ABCDEFFEDCBA9876543210 -> busy_o high 32 cycles, done_o pulses once at cycle 33, keys_valid_o=1; rk[0]=F12186F9, rk[1]=41662B61, rk[31]=9124A012.
- After the above, rk_dec_i=1, rk_addr_i=0 -> rk_data_o=9124A012; rk_addr_i=31 -> F12186F9.
- Pulse start_i at round 10 of an expansion -> ignored; done_o still at cycle 33; schedule unchanged.
- Assert rst at round 15 -> all outputs 0 immediately; all rk read back 0. New start then produces the correct schedule in 32 cycles.
- Back-to-back: second start with key 0 right after return to IDLE -> keys_valid_o drops on acceptance; rk[0] matches the reference model for key 0.
- sm4_ck_gen sweep i=0..31 -> outputs match the SM4 CK table (00070E15 ... 646B7279).

Source files
------------

// File: rtl/sm4_pkg.sv
// ---------------------------------------------------------------------------
// sm4_pkg
// Shared constants and types for the SM4 key-schedule sequencer and its
// helpers. It holds the FK whitening words, the round count, the CK
// generator step sizes and the sequencer state encoding.
// ---------------------------------------------------------------------------
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;

    localparam logic [31:0]  FK0 = 32'hA3B1BAC6;
    localparam logic [31:0]  FK1 = 32'h56AA3350;
    localparam logic [31:0]  FK2 = 32'h677D9197;
    localparam logic [31:0]  FK3 = 32'hB27022DC;
    localparam logic [127:0] FK  = {FK0, FK1, FK2, FK3};

    // CK byte j of round i is (CK_ROUND_STEP*i + CK_BYTE_STEP*j) mod 256
    localparam logic [7:0] CK_BYTE_STEP  = 8'd7;
    localparam logic [7:0] CK_ROUND_STEP = 8'd28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/one_round_for_key_exp.sv
// ---------------------------------------------------------------------------
// one_round_for_key_exp
// One combinational SM4 key-expansion round.
//   {K0,K1,K2,K3} = data_in
//   rk            = K0 ^ L'(tau(K1 ^ K2 ^ K3 ^ CK))
//   result_out    = {K1, K2, K3, rk}
// Ports:
//   data_in          128-bit working key words
//   count_round_in   6-bit round number (informational only)
//   ck_parameter_in  32-bit CK constant for this round
//   result_out       128-bit working key words for the next round
//   rk_o             32-bit round key produced by this round
// ---------------------------------------------------------------------------
module one_round_for_key_exp (
    input  logic [127:0] data_in,
    input  logic [5:0]   count_round_in,
    input  logic [31:0]  ck_parameter_in,
    output logic [127:0] result_out,
    output logic [31:0]  rk_o
);

    // SM4 S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        // entry a sits at bit offset 8*(255-a) = {~a, 3'b000}
        return SBOX[{~a, 3'b000} +: 8];
    endfunction

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] mix, sub;
    logic [31:0] lin;
    logic        unused_round_idx;

    assign {k0, k1, k2, k3} = data_in;
    assign mix = k1 ^ k2 ^ k3 ^ ck_parameter_in;
    assign sub = {sbox(mix[31:24]), sbox(mix[23:16]), sbox(mix[15:8]), sbox(mix[7:0])};
    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    assign lin = sub ^ {sub[18:0], sub[31:19]} ^ {sub[8:0], sub[31:9]};
    assign rk_o       = k0 ^ lin;
    assign result_out = {k1, k2, k3, rk_o};

    assign unused_round_idx = ^count_round_in;

endmodule

// File: rtl/sm4_ck_gen.sv
// ---------------------------------------------------------------------------
// sm4_ck_gen
// Combinational SM4 CK constant generator.
// Ports:
//   idx_i  5-bit round index i
//   ck_o   32-bit CK(i), byte 0 in bits [31:24]
// ---------------------------------------------------------------------------
module sm4_ck_gen
    import sm4_pkg::*;
(
    input  logic [4:0]  idx_i,
    output logic [31:0] ck_o
);

    logic [7:0] base;

    always_comb begin
        ck_o = '0;
        // 8-bit products wrap naturally, giving the mod-256 behaviour
        base = 8'(idx_i) * CK_ROUND_STEP;
        for (int j = 0; j < 4; j++) begin
            ck_o[31-8*j -: 8] = base + 8'(j) * CK_BYTE_STEP;
        end
    end

endmodule

// File: rtl/sm4_key_exp_ctrl.sv
// ---------------------------------------------------------------------------
// sm4_key_exp_ctrl
// SM4 key-schedule sequencer: whitens the master key with FK, runs one
// key-expansion round per clock for 32 rounds and stores the round keys in
// a local register file with a combinational read port.
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   start_i         request expansion, sampled only in IDLE
//   key_i           128-bit master key, MK0 in [127:96]
//   busy_o          high while rounds are running
//   done_o          one-cycle pulse after the last round key is written
//   keys_valid_o    register file holds a complete schedule
//   rk_dec_i        0: read rk[addr], 1: read rk[31-addr]
//   rk_addr_i       read index
//   rk_data_o       round key at the effective index
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start_i
// ST_ROUND | one key-expansion round per clock, counter 0..31
// ST_DONE  | done_o pulse, returns to IDLE on the next edge
// ---------------------------------------------------------------------------
module sm4_key_exp_ctrl
    import sm4_pkg::*;
#(
    parameter int NUM_ROUNDS = SM4_ROUNDS,
    parameter int RK_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [127:0]    key_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            keys_valid_o,
    input  logic            rk_dec_i,
    input  logic [4:0]      rk_addr_i,
    output logic [RK_W-1:0] rk_data_o
);

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [127:0]    blk_q, blk_d;
    logic            valid_q, valid_d;
    logic [RK_W-1:0] rk_q [NUM_ROUNDS];
    logic [RK_W-1:0] rk_d [NUM_ROUNDS];

    logic [31:0]     ck;
    logic [31:0]     rk_new;
    logic [127:0]    blk_next;
    logic [4:0]      rd_idx;

    sm4_ck_gen u_ck_gen (
        .idx_i (cnt_q),
        .ck_o  (ck)
    );

    one_round_for_key_exp u_round (
        .data_in         (blk_q),
        .count_round_in  ({1'b0, cnt_q}),
        .ck_parameter_in (ck),
        .result_out      (blk_next),
        .rk_o            (rk_new)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        valid_d = valid_q;
        rk_d    = rk_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    blk_d   = key_i ^ FK;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                blk_d        = blk_next;
                rk_d[cnt_q]  = rk_new;
                cnt_d        = cnt_q + 5'd1;
                if (cnt_q == 5'(NUM_ROUNDS - 1)) begin
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            valid_q <= valid_d;
            rk_q    <= rk_d;
        end
    end

    assign busy_o       = (state_q == ST_ROUND);
    assign done_o       = (state_q == ST_DONE);
    assign keys_valid_o = valid_q;
    // decrypt order reads the schedule back to front
    assign rd_idx       = rk_dec_i ? (5'(NUM_ROUNDS - 1) - rk_addr_i) : rk_addr_i;
    assign rk_data_o    = rk_q[rd_idx];

endmodule

// File: tb/tb_sm4_key_exp_ctrl.sv
module tb_sm4_key_exp_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         busy_o, done_o, keys_valid_o;
    logic         rk_dec_i = 1'b0;
    logic [4:0]   rk_addr_i = '0;
    logic [31:0]  rk_data_o;

    logic [4:0]   ck_idx = '0;
    logic [31:0]  ck_out;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] KEY_STD = 128'h0123456789ABCDEFFEDCBA9876543210;

    sm4_key_exp_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .key_i        (key_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .keys_valid_o (keys_valid_o),
        .rk_dec_i     (rk_dec_i),
        .rk_addr_i    (rk_addr_i),
        .rk_data_o    (rk_data_o)
    );

    sm4_ck_gen u_ck_ref (
        .idx_i (ck_idx),
        .ck_o  (ck_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [2047:0] tb_sbox = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic [31:0] m_rk [32];

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ck_ref(input int i);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return r;
    endfunction

    function automatic logic [31:0] t_prime(input logic [31:0] a);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = tb_sbox[2047 - 8 * int'(a[8*j +: 8]) -: 8];
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            k[i+4]  = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_ref(i));
            m_rk[i] = k[i+4];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rk[i] = '0;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic verify_schedule(input string tag);
        for (int a = 0; a < 32; a++) begin
            rk_addr_i = 5'(a);
            rk_dec_i  = 1'b0;
            #1;
            chk({tag, "_fwd"}, rk_data_o, m_rk[a]);
            rk_dec_i  = 1'b1;
            #1;
            chk({tag, "_dec"}, rk_data_o, m_rk[31-a]);
        end
        rk_dec_i = 1'b0;
    endtask

    // start an expansion, optionally pulse start_i (with a different key)
    // in cycle pulse_cyc, and check busy/done timing; ends in the IDLE cycle
    task automatic run_expansion(input logic [127:0] key, input int pulse_cyc);
        int busy_n, done_n, done_cyc;
        busy_n = 0; done_n = 0; done_cyc = 0;
        key_i   = key;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("valid_cleared_on_start", keys_valid_o, 1'b0);
        for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                done_cyc = cyc;
            end
            start_i = (cyc == pulse_cyc);
            key_i   = (cyc == pulse_cyc) ? ~key : key;
            if (done_cyc == 0) step();
        end
        start_i = 1'b0;
        key_i   = key;
        chk("busy_cycles", busy_n, 32);
        chk("done_cycle", done_cyc, 33);
        chk("done_count", done_n, 1);
        chk("busy_low_in_done", busy_o, 1'b0);
        chk("valid_at_done", keys_valid_o, 1'b1);
        step();
        chk("done_one_pulse", done_o, 1'b0);
        chk("idle_not_busy", busy_o, 1'b0);
        chk("valid_held_idle", keys_valid_o, 1'b1);
        model_expand(key);
    endtask

    typedef struct {
        logic        dec;
        logic [4:0]  addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] k;

        vecs[0] = '{1'b0, 5'd0,  32'hF12186F9};
        vecs[1] = '{1'b0, 5'd1,  32'h41662B61};
        vecs[2] = '{1'b0, 5'd31, 32'h9124A012};
        vecs[3] = '{1'b1, 5'd0,  32'h9124A012};
        vecs[4] = '{1'b1, 5'd31, 32'hF12186F9};
        vecs[5] = '{1'b1, 5'd30, 32'h41662B61};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_valid", keys_valid_o, 1'b0);
        chk("rst_rd", rk_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_busy", busy_o, 1'b0);
        model_clear();
        verify_schedule("rst_zero");

        // standard vector, fixed-value table
        run_expansion(KEY_STD, 0);
        for (int v = 0; v < 6; v++) begin
            rk_dec_i  = vecs[v].dec;
            rk_addr_i = vecs[v].addr;
            #1;
            chk($sformatf("vec%0d", v), rk_data_o, vecs[v].exp);
        end
        verify_schedule("std");

        // start pulse mid-expansion (round 10) is ignored
        k = {$urandom, $urandom, $urandom, $urandom};
        run_expansion(k, 11);
        verify_schedule("ignored_start");

        // back-to-back start with key 0 immediately in IDLE
        run_expansion(128'h0, 0);
        verify_schedule("key0");

        // start held high: ignored in DONE, re-triggers in first IDLE cycle
        k = {$urandom, $urandom, $urandom, $urandom};
        key_i   = k;
        start_i = 1'b1;
        step();
        repeat (32) step();
        chk("held_done", done_o, 1'b1);
        step();
        chk("held_idle_busy", busy_o, 1'b0);
        chk("held_idle_done", done_o, 1'b0);
        step();
        chk("held_retrigger_busy", busy_o, 1'b1);
        chk("held_retrigger_valid", keys_valid_o, 1'b0);
        start_i = 1'b0;
        repeat (32) step();
        chk("held_done2", done_o, 1'b1);
        step();
        model_expand(k);
        verify_schedule("held");

        // async reset at round 15
        k = {$urandom, $urandom, $urandom, $urandom};
        key_i   = k;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (15) step();
        chk("pre_rst_busy", busy_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        chk("midrst_valid", keys_valid_o, 1'b0);
        rk_addr_i = 5'd0;
        rk_dec_i  = 1'b0;
        #1;
        chk("midrst_rd", rk_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        verify_schedule("midrst_zero");
        run_expansion(KEY_STD, 0);
        verify_schedule("after_rst");

        // randomized keys and random reads
        for (int r = 0; r < 3; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run_expansion(k, 0);
            for (int n = 0; n < 8; n++) begin
                rk_dec_i  = 1'($urandom_range(0, 1));
                rk_addr_i = 5'($urandom_range(0, 31));
                #1;
                chk("rand_rd", rk_data_o,
                    m_rk[rk_dec_i ? (31 - int'(rk_addr_i)) : int'(rk_addr_i)]);
            end
        end

        // CK generator sweep
        for (int i = 0; i < 32; i++) begin
            ck_idx = 5'(i);
            #1;
            chk($sformatf("ck%0d", i), ck_out, ck_ref(i));
        end
        ck_idx = 5'd0;
        #1;
        chk("ck_const0", ck_out, 32'h00070E15);
        ck_idx = 5'd1;
        #1;
        chk("ck_const1", ck_out, 32'h1C232A31);
        ck_idx = 5'd31;
        #1;
        chk("ck_const31", ck_out, 32'h646B7279);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
